// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C slave register file: protocol states and byte layout.
package i2c_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STARTED = 2'd1,
        S_GET_PTR = 2'd2,
        S_DATA    = 2'd3
    } state_t;

    localparam int BYTE_W = 8;
    localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_regfile_bank.sv
// Register bank: stages incoming bytes in a shadow copy and commits all staged
// registers at once, so a multi-byte value never appears half-written.
module i2c_regfile_bank
    import i2c_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int PTR_BITS = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stage_en,
    input  logic [PTR_BITS-1:0]        stage_idx,
    input  logic [BYTE_W-1:0]          stage_data,
    input  logic                       commit,
    input  logic                       discard,
    output logic [BYTE_W*NUM_REGS-1:0] regs_out,
    output logic                       update,
    output logic [NUM_REGS-1:0]        update_mask
);

    logic [BYTE_W-1:0]          shadow_q [NUM_REGS];
    logic [BYTE_W-1:0]          shadow_d [NUM_REGS];
    logic [NUM_REGS-1:0]        pend_mask_q, pend_mask_d;
    logic [BYTE_W*NUM_REGS-1:0] regs_q, regs_d;
    logic                       update_q, update_d;
    logic [NUM_REGS-1:0]        update_mask_q, update_mask_d;

    always_comb begin
        shadow_d      = shadow_q;
        pend_mask_d   = pend_mask_q;
        regs_d        = regs_q;
        update_d      = 1'b0;
        update_mask_d = update_mask_q;
        if (commit) begin
            // An empty transaction commits nothing and must not pulse update.
            if (pend_mask_q != '0) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (pend_mask_q[i]) begin
                        regs_d[BYTE_W*i +: BYTE_W] = shadow_q[i];
                    end
                end
                update_d      = 1'b1;
                update_mask_d = pend_mask_q;
            end
            pend_mask_d = '0;
        end else if (discard) begin
            pend_mask_d = '0;
        end else if (stage_en) begin
            shadow_d[stage_idx]    = stage_data;
            pend_mask_d[stage_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
            end
            pend_mask_q   <= '0;
            regs_q        <= '0;
            update_q      <= 1'b0;
            update_mask_q <= '0;
        end else begin
            shadow_q      <= shadow_d;
            pend_mask_q   <= pend_mask_d;
            regs_q        <= regs_d;
            update_q      <= update_d;
            update_mask_q <= update_mask_d;
        end
    end

    assign regs_out    = regs_q;
    assign update      = update_q;
    assign update_mask = update_mask_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// Byte-level write-only I2C slave: address byte, register pointer, then
// auto-incrementing data bytes committed to the bank on stop.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDRESS = 7'h00,
    parameter int         NUM_REGS    = 8,
    parameter int         PTR_BITS    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       wr,
    input  logic [BYTE_W-1:0]          write_data,
    output logic                       wr_ack,
    output logic [BYTE_W*NUM_REGS-1:0] regs_out,
    output logic                       update,
    output logic [NUM_REGS-1:0]        update_mask
);

    state_t              state_q, state_d;
    logic [PTR_BITS-1:0] ptr_q, ptr_d;
    logic                wr_ack_q, wr_ack_d;
    logic                stage_en, commit, discard;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wr_ack_d = wr_ack_q;
        stage_en = 1'b0;
        commit   = 1'b0;
        discard  = 1'b0;
        if (start) begin
            // Repeated start abandons anything staged by the previous transaction.
            state_d = S_STARTED;
            discard = 1'b1;
        end else if (stop) begin
            commit  = (state_q == S_GET_PTR) || (state_q == S_DATA);
            state_d = S_IDLE;
        end else if (wr) begin
            unique case (state_q)
                S_IDLE: wr_ack_d = 1'b0;
                S_STARTED: begin
                    if (write_data[BYTE_W-1:1] == I2C_ADDRESS && write_data[RW_BIT] == 1'b0) begin
                        wr_ack_d = 1'b1;
                        state_d  = S_GET_PTR;
                    end else begin
                        wr_ack_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
                S_GET_PTR: begin
                    if ({1'b0, write_data} < 9'(NUM_REGS)) begin
                        ptr_d    = write_data[PTR_BITS-1:0];
                        wr_ack_d = 1'b1;
                        state_d  = S_DATA;
                    end else begin
                        wr_ack_d = 1'b0;
                        discard  = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_DATA: begin
                    stage_en = 1'b1;
                    ptr_d    = ptr_q + 1'b1;
                    wr_ack_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    assign wr_ack = wr_ack_q;

    i2c_regfile_bank #(
        .NUM_REGS (NUM_REGS),
        .PTR_BITS (PTR_BITS)
    ) u_bank (
        .clk         (clk),
        .rst_n       (reset),
        .stage_en    (stage_en),
        .stage_idx   (ptr_q),
        .stage_data  (write_data),
        .commit      (commit),
        .discard     (discard),
        .regs_out    (regs_out),
        .update      (update),
        .update_mask (update_mask)
    );

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: directed table of transactions plus random
// transactions checked against a transaction-level model.
module tb_i2c_slave_regfile;

    localparam int         NR   = 8;
    localparam logic [6:0] ADDR = 7'h21;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          wr = 1'b0;
    logic [7:0]    write_data = 8'h00;
    logic          wr_ack;
    logic [8*NR-1:0] regs_out;
    logic          update;
    logic [NR-1:0] update_mask;

    i2c_slave_regfile #(
        .I2C_ADDRESS (ADDR),
        .NUM_REGS    (NR),
        .PTR_BITS    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .wr          (wr),
        .write_data  (write_data),
        .wr_ack      (wr_ack),
        .regs_out    (regs_out),
        .update      (update),
        .update_mask (update_mask)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: bytes of the current transaction kept in a queue,
    // their effect applied to the register image only at stop.
    logic [63:0] m_regs;
    logic [7:0]  m_mask;
    bit          m_alive;
    logic [7:0]  m_bytes[$];

    function automatic void m_reset();
        m_regs  = '0;
        m_mask  = '0;
        m_alive = 0;
        m_bytes.delete();
    endfunction

    function automatic void m_start();
        m_alive = 1;
        m_bytes.delete();
    endfunction

    function automatic bit m_byte(input logic [7:0] b);
        bit ok;
        if (!m_alive) return 0;
        if (m_bytes.size() == 0)      ok = (b == {ADDR, 1'b0});
        else if (m_bytes.size() == 1) ok = (int'(b) < NR);
        else                          ok = 1;
        if (ok) m_bytes.push_back(b);
        else begin
            m_alive = 0;
            m_bytes.delete();
        end
        return ok;
    endfunction

    function automatic bit m_stop();
        bit upd = 0;
        if (m_alive && m_bytes.size() >= 3) begin
            m_mask = '0;
            for (int k = 2; k < m_bytes.size(); k++) begin
                int idx = (int'(m_bytes[1]) + k - 2) % NR;
                m_regs[8*idx +: 8] = m_bytes[k];
                m_mask[idx] = 1'b1;
            end
            upd = 1;
        end
        m_alive = 0;
        m_bytes.delete();
        return upd;
    endfunction

    task automatic drv_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        m_start();
    endtask

    task automatic drv_byte(input logic [7:0] b, output logic ack);
        bit exp;
        @(negedge clk);
        wr = 1'b1;
        write_data = b;
        @(negedge clk);
        wr = 1'b0;
        write_data = $urandom_range(0, 255);
        exp = m_byte(b);
        ack = wr_ack;
        chk("ack_model", {63'd0, wr_ack}, {63'd0, exp});
    endtask

    task automatic drv_stop(output logic upd, output logic [7:0] mask, output logic [63:0] regs);
        bit exp;
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        exp  = m_stop();
        upd  = update;
        mask = update_mask;
        regs = regs_out;
        chk("upd_model", {63'd0, update}, {63'd0, exp});
        chk("mask_model", {56'd0, update_mask}, {56'd0, m_mask});
        chk("regs_model", regs_out, m_regs);
        @(negedge clk);
        chk("upd_one_cycle", {63'd0, update}, 64'd0);
    endtask

    typedef enum int {OP_S, OP_P, OP_B} op_e;
    typedef struct {
        op_e         op;
        logic [7:0]  data;
        logic        exp_ack;
        logic        exp_upd;
        logic [7:0]  exp_mask;
        logic [63:0] exp_regs;
    } vec_t;
    vec_t tbl[$];

    function automatic void t_s();
        tbl.push_back('{OP_S, 8'h00, 1'b0, 1'b0, 8'h00, 64'd0});
    endfunction
    function automatic void t_b(input logic [7:0] d, input logic a);
        tbl.push_back('{OP_B, d, a, 1'b0, 8'h00, 64'd0});
    endfunction
    function automatic void t_p(input logic u, input logic [7:0] m, input logic [63:0] r);
        tbl.push_back('{OP_P, 8'h00, 1'b0, u, m, r});
    endfunction

    logic        o_ack, o_upd;
    logic [7:0]  o_mask;
    logic [63:0] o_regs;

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", {63'd0, wr_ack}, 64'd0);
        chk("rst_regs", regs_out, 64'd0);
        chk("rst_upd", {63'd0, update}, 64'd0);
        chk("rst_mask", {56'd0, update_mask}, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic two-byte write to reg2/reg3.
        t_s(); t_b(8'h42, 1); t_b(8'h02, 1); t_b(8'hAA, 1); t_b(8'hBB, 1);
        t_p(1, 8'h0C, 64'h0000_0000_BBAA_0000);
        // Wrong address, then read request: all NACKed, nothing changes.
        t_s(); t_b(8'h44, 0); t_b(8'h10, 0); t_b(8'h20, 0);
        t_p(0, 8'h0C, 64'h0000_0000_BBAA_0000);
        t_s(); t_b(8'h43, 0); t_b(8'h01, 0);
        t_p(0, 8'h0C, 64'h0000_0000_BBAA_0000);
        // Out-of-range pointer.
        t_s(); t_b(8'h42, 1); t_b(8'h08, 0); t_b(8'h55, 0);
        t_p(0, 8'h0C, 64'h0000_0000_BBAA_0000);
        // Pointer wraps from reg7 to reg0.
        t_s(); t_b(8'h42, 1); t_b(8'h06, 1); t_b(8'h11, 1); t_b(8'h22, 1); t_b(8'h33, 1);
        t_p(1, 8'hC1, 64'h2211_0000_BBAA_0033);
        // Repeated start drops the write to reg1.
        t_s(); t_b(8'h42, 1); t_b(8'h01, 1); t_b(8'h55, 1);
        t_s(); t_b(8'h42, 1); t_b(8'h04, 1); t_b(8'h66, 1);
        t_p(1, 8'h10, 64'h2211_0066_BBAA_0033);
        // Nine bytes from reg7: reg7 overwritten, last value wins, mask all ones.
        t_s(); t_b(8'h42, 1); t_b(8'h07, 1);
        for (int i = 1; i <= 9; i++) t_b(8'(i), 1);
        t_p(1, 8'hFF, 64'h0908_0706_0504_0302);

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                OP_S: drv_start();
                OP_B: begin
                    drv_byte(tbl[i].data, o_ack);
                    chk($sformatf("tbl%0d_ack", i), {63'd0, o_ack}, {63'd0, tbl[i].exp_ack});
                end
                default: begin
                    drv_stop(o_upd, o_mask, o_regs);
                    chk($sformatf("tbl%0d_upd", i), {63'd0, o_upd}, {63'd0, tbl[i].exp_upd});
                    chk($sformatf("tbl%0d_mask", i), {56'd0, o_mask}, {56'd0, tbl[i].exp_mask});
                    chk($sformatf("tbl%0d_regs", i), o_regs, tbl[i].exp_regs);
                end
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Random transactions against the model.
        for (int t = 0; t < 150; t++) begin
            int ndata;
            if ($urandom_range(0, 9) == 0) drv_byte(8'($urandom_range(0, 255)), o_ack);
            drv_start();
            if ($urandom_range(0, 4) != 0) drv_byte({ADDR, 1'b0}, o_ack);
            else drv_byte(8'($urandom_range(0, 255)), o_ack);
            if ($urandom_range(0, 7) != 0) begin
                drv_byte(8'($urandom_range(0, 11)), o_ack);
                ndata = $urandom_range(0, 11);
                for (int k = 0; k < ndata; k++) begin
                    drv_byte(8'($urandom_range(0, 255)), o_ack);
                    if ($urandom_range(0, 29) == 0) begin
                        drv_start();
                        drv_byte({ADDR, 1'b0}, o_ack);
                        drv_byte(8'($urandom_range(0, 7)), o_ack);
                    end
                end
            end
            drv_stop(o_upd, o_mask, o_regs);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset between a data byte and the stop discards everything at once.
        drv_start();
        drv_byte({ADDR, 1'b0}, o_ack);
        drv_byte(8'h00, o_ack);
        drv_byte(8'h77, o_ack);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("async_rst_regs", regs_out, 64'd0);
        chk("async_rst_ack", {63'd0, wr_ack}, 64'd0);
        chk("async_rst_mask", {56'd0, update_mask}, 64'd0);
        m_reset();
        @(negedge clk) reset = 1'b1;
        drv_stop(o_upd, o_mask, o_regs);
        chk("post_rst_upd", {63'd0, o_upd}, 64'd0);
        chk("post_rst_regs", o_regs, 64'd0);
        chk("post_rst_ack", {63'd0, wr_ack}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Byte-level consumer that sits directly downstream of the I2C slave serializer.
- Takes the serializer's start/stop/byte-strobe stream and drives its wr_ack.
- Implements an addressed bank of NUM_REGS 8-bit registers. The first data byte is a register pointer; following bytes write consecutive registers with auto-increment.
- Writes are staged and committed atomically on stop, so downstream logic never sees a half-updated multi-byte value.

Parameters:
- I2C_ADDRESS, 0, 7-bit slave address matched against write_data[7:1].
- NUM_REGS, 8, number of 8-bit registers; a power of two, 2..128.
- PTR_BITS, 3, log2(NUM_REGS); width of the register pointer.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle pulse: I2C start or repeated start.
- stop  input  1  one-cycle pulse: I2C stop.
- wr  input  1  one-cycle strobe: write_data holds a received byte.
- write_data  input  8  received byte, valid when wr=1.
- wr_ack  output  1  1 = ACK the current byte, 0 = NACK; registered.
- regs_out  output  8*NUM_REGS  committed registers; reg i is at [8*i+7:8*i].
- update  output  1  one-cycle pulse when a commit occurs.
- update_mask  output  NUM_REGS  registers changed by the last commit; held until the next commit.

Behaviour:
- Reset (reset=0, async): regs_out=0, shadow=0, pend_mask=0, ptr=0, wr_ack=0, update=0, update_mask=0, state=S_IDLE.
- Reset mid-transaction discards all staged data immediately.
- wr_ack is registered on the clock edge that samples wr, so it is valid 1 cycle after wr. The serializer needs it before SCL next falls, which is far later.
- Priority each cycle: start > stop > wr.
- States:
  - S_IDLE: wr seen -> wr_ack<=0. start -> S_STARTED.
  - S_STARTED: on wr, if write_data[7:1]==I2C_ADDRESS and write_data[0]==0 -> wr_ack<=1, S_GET_PTR. Otherwise (other address or a read request) -> wr_ack<=0, S_IDLE. Reads are not supported.
  - S_GET_PTR: on wr, if write_data<NUM_REGS -> ptr<=write_data[PTR_BITS-1:0], wr_ack<=1, S_DATA. Otherwise -> wr_ack<=0, pend_mask<=0, S_IDLE.
  - S_DATA: on wr -> shadow[ptr]<=write_data, pend_mask[ptr]<=1, ptr<=ptr+1 mod NUM_REGS (wraps NUM_REGS-1 -> 0), wr_ack<=1.
- Start in any non-idle state -> S_STARTED and pend_mask<=0. A repeated start discards uncommitted writes.
- Stop in S_GET_PTR or S_DATA:
  - If pend_mask!=0: on the next edge, regs_out[i]<=shadow[i] for every set bit, update<=1 for exactly 1 cycle, update_mask<=pend_mask, pend_mask<=0.
  - Else: no update pulse.
  - Then S_IDLE.
- Stop in S_IDLE or S_STARTED -> S_IDLE, no effect.
- A register written more than once in one transaction commits its last value.
- More than NUM_REGS data bytes wrap and overwrite staged values. update_mask is then all ones.
- ptr does not persist across transactions; every write transaction must supply a pointer.
- Registers not in pend_mask keep their values through a commit.

Decomposition:
- Package i2c_pkg:
  - state encodings for S_IDLE, S_STARTED, S_GET_PTR, S_DATA;
  - the R/W bit index and byte width constants.
- Sub-module i2c_regfile_bank:
  - holds shadow[], pend_mask, regs_out, update and update_mask;
  - stage port: stage_en, stage_idx, stage_data;
  - control inputs: commit, discard.
  - The top level holds only the protocol FSM, ptr and wr_ack.

Test Plan:
- I2C_ADDRESS=0x21. Bytes 0x42, 0x02, 0xAA, 0xBB, then stop -> all ACKed. 1 cycle after stop: update=1, update_mask=0x0C, reg2=0xAA, reg3=0xBB, others 0.
- Address byte 0x44, then data bytes -> every wr_ack=0, no update pulse, regs_out unchanged. Same result for read-request byte 0x43.
- Pointer byte 0x08 with NUM_REGS=8 -> wr_ack=0. Following data NACKed; stop gives no update.
- Pointer 0x06, data 0x11, 0x22, 0x33 -> reg6=0x11, reg7=0x22, reg0=0x33 (wrap), update_mask=0xC1.
- Pointer 0x01, data 0x55, repeated start, new transaction with pointer 0x04, data 0x66, stop -> reg1 unchanged, reg4=0x66, update_mask=0x10.
- Reset pulled low between data byte and stop -> regs_out=0 immediately. No update on the later stop; wr_ack=0.
